// File: rtl/logcap_pkg.sv
// logcap_pkg: shared definitions for the logic capture command engine.
//   - capture core function codes
//   - status bit positions
//   - command engine FSM state type
//   - burst length normalisation helper
package logcap_pkg;

  // Function codes understood by the capture core
  localparam logic [7:0] FC_NOP              = 8'h00;
  localparam logic [7:0] FC_START            = 8'h01;
  localparam logic [7:0] FC_ABORT            = 8'h02;
  localparam logic [7:0] FC_TRIG_CFG         = 8'h03;
  localparam logic [7:0] FC_BUF_CFG          = 8'h04;
  localparam logic [7:0] FC_READ_TRACE_DATA  = 8'h05;
  localparam logic [7:0] FC_READ_TRACE_SIZE  = 8'h06;
  localparam logic [7:0] FC_READ_TRIG_SAMPLE = 8'h07;
  localparam logic [7:0] FC_ACK              = 8'h08;
  localparam logic [7:0] FC_RESET            = 8'h09;

  // Status bit positions
  localparam int ST_IDLE_BIT = 0;
  localparam int ST_ACK_BIT  = 3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DRIVE      = 3'd1,
    S_WAIT_ACK   = 3'd2,
    S_ACK_STROBE = 3'd3,
    S_WAIT_CLR   = 3'd4,
    S_RSP        = 3'd5
  } state_e;

  // A burst of zero still issues the command once
  function automatic logic [15:0] burst_norm(input logic [15:0] b);
    return (b == 16'd0) ? 16'd1 : b;
  endfunction

endpackage

// File: rtl/logcap_ack_timer.sv
// logcap_ack_timer: loadable saturating wait counter.
//   clk, resetn : clock, asynchronous active-low reset
//   i_clear     : reset the count to zero (has priority over i_inc)
//   i_inc       : count one more waiting cycle (saturates at LIMIT)
//   o_last      : the count is LIMIT-1, so the current waiting cycle is
//                 the LIMIT-th one and the wait expires on this edge
module logcap_ack_timer #(
  parameter int LIMIT = 1024,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAX_VAL  = CW'(LIMIT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_last = (r_count == LAST_VAL);

endmodule

// File: rtl/logcap_cmd_engine.sv
// logcap_cmd_engine: hub-side command engine for the logic capture core.
// Takes host requests (cmd, register payload, burst count), issues the
// command to the core, waits for ack, acknowledges it with CMD_ACK, and
// returns the core's output registers as one response per repetition.
//
// Host request  : req_valid/req_ready, req_cmd, req_regs, req_burst
// Host response : rsp_valid/rsp_ready, rsp_data, rsp_status, rsp_timeout,
//                 rsp_last
// Capture core  : command, commandStrobe, reg_in_bus, reg_out_bus, status
// Misc          : core_idle (registered status[IDLE_BIT]),
//                 o_dbg_state (current FSM state)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once rsp_valid is high, all rsp_* outputs stay stable until
// that transfer; req_ready is only high in IDLE, so req_valid elsewhere is
// ignored.
module logcap_cmd_engine
  import logcap_pkg::*;
#(
  parameter int         NUM_REGS     = 8,
  parameter int         REG_W        = 8,
  parameter int         ACK_TIMEOUT  = 1024,
  parameter int         ACK_BIT      = ST_ACK_BIT,
  parameter int         IDLE_BIT     = ST_IDLE_BIT,
  parameter logic [7:0] CMD_ACK_CODE = FC_ACK
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_cmd,
  input  logic [NUM_REGS*REG_W-1:0] req_regs,
  input  logic [15:0]               req_burst,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [NUM_REGS*REG_W-1:0] rsp_data,
  output logic [7:0]                rsp_status,
  output logic                      rsp_timeout,
  output logic                      rsp_last,
  output logic [7:0]                command,
  output logic                      commandStrobe,
  output logic [NUM_REGS*REG_W-1:0] reg_in_bus,
  input  logic [NUM_REGS*REG_W-1:0] reg_out_bus,
  input  logic [7:0]                status,
  output logic                      core_idle,
  output logic [2:0]                o_dbg_state
);

  localparam int DW = NUM_REGS * REG_W;

  state_e          r_state;
  logic [7:0]      r_cmd;
  logic [DW-1:0]   r_reg_in;
  logic [15:0]     r_burst_rem;
  logic [7:0]      r_command;
  logic            r_strobe;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic [7:0]      r_rsp_status;
  logic            r_rsp_timeout;
  logic            r_rsp_last;
  logic            r_core_idle;

  logic w_ack;
  logic w_tmr_clear;
  logic w_tmr_inc;
  logic w_tmr_last;

  assign w_ack = status[ACK_BIT];

  // The counter is zeroed in the single-cycle strobe states, so every wait
  // (for ack, then for ack to drop) starts from zero.
  assign w_tmr_clear = (r_state == S_DRIVE) || (r_state == S_ACK_STROBE);
  assign w_tmr_inc   = ((r_state == S_WAIT_ACK) && !w_ack) ||
                       ((r_state == S_WAIT_CLR) &&  w_ack);

  logcap_ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_tmr_clear),
    .i_inc   (w_tmr_inc),
    .o_last  (w_tmr_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_core_idle <= 1'b0;
    end else begin
      r_core_idle <= status[IDLE_BIT];
    end
  end

  // Outputs are registered and set on the transition into the state where
  // they apply, so the strobe is visible for exactly the DRIVE/ACK_STROBE
  // cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_cmd         <= FC_NOP;
      r_reg_in      <= '0;
      r_burst_rem   <= 16'd0;
      r_command     <= FC_NOP;
      r_strobe      <= 1'b0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_status  <= 8'h00;
      r_rsp_timeout <= 1'b0;
      r_rsp_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_command <= FC_NOP;
          r_strobe  <= 1'b0;
          if (req_valid && r_req_ready) begin
            r_cmd         <= req_cmd;
            r_reg_in      <= req_regs;
            r_burst_rem   <= burst_norm(req_burst);
            r_command     <= req_cmd;
            r_strobe      <= 1'b1;
            r_req_ready   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_last    <= 1'b0;
            r_state       <= S_DRIVE;
          end else begin
            r_req_ready <= 1'b1;
          end
        end

        S_DRIVE: begin
          r_strobe <= 1'b0;
          r_state  <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (w_ack) begin
            r_rsp_data    <= reg_out_bus;
            r_rsp_status  <= status;
            r_rsp_timeout <= 1'b0;
            r_command     <= CMD_ACK_CODE;
            r_strobe      <= 1'b1;
            r_state       <= S_ACK_STROBE;
          end else if (w_tmr_last) begin
            // Abort: the rest of the burst is dropped
            r_rsp_data    <= '0;
            r_rsp_status  <= status;
            r_rsp_timeout <= 1'b1;
            r_rsp_last    <= 1'b1;
            r_burst_rem   <= 16'd0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end

        S_ACK_STROBE: begin
          r_strobe <= 1'b0;
          r_state  <= S_WAIT_CLR;
        end

        S_WAIT_CLR: begin
          if (!w_ack) begin
            r_rsp_last  <= (r_burst_rem == 16'd1);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end else if (w_tmr_last) begin
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_last    <= 1'b1;
            r_burst_rem   <= 16'd0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_burst_rem != 16'd0) begin
              r_burst_rem <= r_burst_rem - 16'd1;
            end
            if ((r_burst_rem > 16'd1) && !r_rsp_timeout) begin
              // Re-issue with the latched command and registers
              r_command <= r_cmd;
              r_strobe  <= 1'b1;
              r_state   <= S_DRIVE;
            end else begin
              r_command   <= FC_NOP;
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end

        default: begin
          r_command   <= FC_NOP;
          r_strobe    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_status    = r_rsp_status;
  assign rsp_timeout   = r_rsp_timeout;
  assign rsp_last      = r_rsp_last;
  assign command       = r_command;
  assign commandStrobe = r_strobe;
  assign reg_in_bus    = r_reg_in;
  assign core_idle     = r_core_idle;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_logcap_cmd_engine.sv
// Bench for logcap_cmd_engine with a short ack timeout. A behavioural
// capture-core model answers commands; expected command strobes and
// responses are queued per test and checked by one compare process.
module tb_logcap_cmd_engine;

  localparam int         DW        = 64;
  localparam int         TO        = 16;
  localparam int         ACK_BIT   = 3;
  localparam int         IDLE_BIT  = 0;
  localparam logic [7:0] C_BUF_CFG = 8'h04;
  localparam logic [7:0] C_RD_DATA = 8'h05;
  localparam logic [7:0] C_RD_SIZE = 8'h06;
  localparam logic [7:0] C_RD_TRIG = 8'h07;
  localparam logic [7:0] C_ACK     = 8'h08;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  initial forever #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_cmd;
  logic [DW-1:0] req_regs;
  logic [15:0]   req_burst;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [7:0]    rsp_status;
  logic          rsp_timeout;
  logic          rsp_last;
  logic [7:0]    command;
  logic          commandStrobe;
  logic [DW-1:0] reg_in_bus;
  logic [DW-1:0] reg_out_bus;
  logic [7:0]    status;
  logic          core_idle;
  logic [2:0]    dbg_state;

  logcap_cmd_engine #(
    .NUM_REGS    (8),
    .REG_W       (8),
    .ACK_TIMEOUT (TO),
    .ACK_BIT     (ACK_BIT),
    .IDLE_BIT    (IDLE_BIT),
    .CMD_ACK_CODE(C_ACK)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_regs     (req_regs),
    .req_burst    (req_burst),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .rsp_timeout  (rsp_timeout),
    .rsp_last     (rsp_last),
    .command      (command),
    .commandStrobe(commandStrobe),
    .reg_in_bus   (reg_in_bus),
    .reg_out_bus  (reg_out_bus),
    .status       (status),
    .core_idle    (core_idle),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    status;
    logic          chk_status;
    logic          last;
    logic          timeout;
  } rsp_t;

  rsp_t       exp_rsp_q[$];
  logic [7:0] exp_q[$];      // expected command strobes, in order
  int checks   = 0;
  int failures = 0;

  // core model controls
  logic          ack_en    = 1'b1;
  int            ack_delay = 3;
  int            ack_cnt   = 0;
  logic [DW-1:0] core_val  = '0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic [DW-1:0] d, input logic [7:0] s,
                                  input logic cs, input logic l, input logic t);
    rsp_t r;
    r.data = d; r.status = s; r.chk_status = cs; r.last = l; r.timeout = t;
    return r;
  endfunction

  // ---------------- capture core model ----------------
  // Raises ack ack_delay clocks after a non-ACK strobe, presenting the
  // next value of core_val on reg_out_bus; drops ack on a CMD_ACK strobe.
  initial begin : core_model
    status      = 8'h01;
    reg_out_bus = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        status  = 8'h01;
        ack_cnt = 0;
      end else begin
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) begin
            status[ACK_BIT] = 1'b1;
            reg_out_bus     = core_val;
            core_val        = core_val + 1;
          end
        end
        if (commandStrobe) begin
          if (command == C_ACK) begin
            status[ACK_BIT]  = 1'b0;
            status[IDLE_BIT] = 1'b1;
          end else begin
            status[IDLE_BIT] = 1'b0;
            if (ack_en) ack_cnt = ack_delay;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic          prev_rst    = 1'b0;
    logic          prev_strobe = 1'b0;
    logic          prev_valid  = 1'b0;
    logic          prev_hs     = 1'b0;
    logic [7:0]    prev_status = 8'h00;
    logic [DW-1:0] prev_data   = '0;
    logic [9:0]    prev_meta   = '0;
    rsp_t          e;
    forever begin
      @(negedge clk);
      if (resetn && prev_rst) begin
        check("core_idle", {63'd0, core_idle}, {63'd0, prev_status[IDLE_BIT]});
        if (commandStrobe) begin
          check("strobe_gap", {63'd0, prev_strobe}, 64'd0);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_strobe: got command %0h expected no strobe", command);
          end else begin
            check("strobe_cmd", {56'd0, command}, {56'd0, exp_q.pop_front()});
          end
        end
        if (rsp_valid) begin
          check("no_strobe_in_rsp", {63'd0, commandStrobe}, 64'd0);
          check("ready_low_busy", {63'd0, req_ready}, 64'd0);
          if (prev_valid && !prev_hs) begin
            check("rsp_data_stable", rsp_data, prev_data);
            check("rsp_meta_stable", {54'd0, rsp_status, rsp_last, rsp_timeout}, {54'd0, prev_meta});
          end
          if (rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_rsp: got data %0h expected no response", rsp_data);
            end else begin
              e = exp_rsp_q.pop_front();
              check("rsp_data", rsp_data, e.data);
              check("rsp_last", {63'd0, rsp_last}, {63'd0, e.last});
              check("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.timeout});
              if (e.chk_status) check("rsp_status", {56'd0, rsp_status}, {56'd0, e.status});
            end
          end
        end
      end
      prev_rst    = resetn;
      prev_strobe = commandStrobe;
      prev_valid  = rsp_valid;
      prev_hs     = rsp_valid && rsp_ready;
      prev_status = status;
      prev_data   = rsp_data;
      prev_meta   = {rsp_status, rsp_last, rsp_timeout};
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_req(input logic [7:0] cmd, input logic [DW-1:0] regs, input logic [15:0] burst);
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("req_ready_before_send", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_cmd = cmd; req_regs = regs; req_burst = burst;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("accept_strobe", {63'd0, commandStrobe}, 64'd1);
    check("accept_command", {56'd0, command}, {56'd0, cmd});
    check("reg_in_bus", reg_in_bus, regs);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (exp_rsp_q.size() != 0 || exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL wait_done: %0d responses and %0d strobes outstanding, required 0",
               exp_rsp_q.size(), exp_q.size());
    end
    check("idle_ready", {63'd0, req_ready}, 64'd1);
    check("idle_command", {56'd0, command}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd0);
    check({tag, "_command"}, {56'd0, command}, 64'd0);
    check({tag, "_strobe"}, {63'd0, commandStrobe}, 64'd0);
    check({tag, "_reg_in_bus"}, reg_in_bus, 64'd0);
    check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_rsp_data"}, rsp_data, 64'd0);
    check({tag, "_rsp_status"}, {56'd0, rsp_status}, 64'd0);
    check({tag, "_rsp_timeout_last"}, {62'd0, rsp_timeout, rsp_last}, 64'd0);
    check({tag, "_core_idle"}, {63'd0, core_idle}, 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    int n;
    req_valid = 1'b0; req_cmd = 8'h00; req_regs = '0; req_burst = 16'd0;
    rsp_ready = 1'b1;

    // Reset values
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #3 resetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Single BUF_CFG, ack 3 clocks after strobe
    core_val = 64'h1122_3344_5566_7700;
    exp_q.push_back(C_BUF_CFG); exp_q.push_back(C_ACK);
    exp_rsp_q.push_back(mk_rsp(64'h1122_3344_5566_7700, 8'h08, 1'b1, 1'b1, 1'b0));
    send_req(C_BUF_CFG, {32'd20, 32'd110}, 16'd1);
    wait_done(100);

    // READ_TRACE_DATA burst of 4, data 0..3
    core_val = 64'h0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(C_RD_DATA); exp_q.push_back(C_ACK);
    end
    exp_rsp_q.push_back(mk_rsp(64'h0, 8'h08, 1'b1, 1'b0, 1'b0));
    exp_rsp_q.push_back(mk_rsp(64'h1, 8'h08, 1'b1, 1'b0, 1'b0));
    exp_rsp_q.push_back(mk_rsp(64'h2, 8'h08, 1'b1, 1'b0, 1'b0));
    exp_rsp_q.push_back(mk_rsp(64'h3, 8'h08, 1'b1, 1'b1, 1'b0));
    send_req(C_RD_DATA, 64'h0, 16'd4);
    wait_done(300);

    // Ack never arrives: timeout after 16 clocks in WAIT_ACK, no CMD_ACK
    ack_en = 1'b0;
    exp_q.push_back(C_RD_DATA);
    exp_rsp_q.push_back(mk_rsp(64'h0, 8'h00, 1'b0, 1'b1, 1'b1));
    send_req(C_RD_DATA, 64'h0000_0000_0000_BEEF, 16'd3);
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    // one DRIVE cycle plus 16 waiting cycles
    check("timeout_latency", 64'(n), 64'd17);
    wait_done(50);
    ack_en = 1'b1;

    // Backpressure during burst of 2; stray requests must be ignored
    rsp_ready = 1'b0;
    core_val  = 64'hA0;
    exp_q.push_back(C_RD_SIZE); exp_q.push_back(C_ACK);
    exp_q.push_back(C_RD_SIZE); exp_q.push_back(C_ACK);
    exp_rsp_q.push_back(mk_rsp(64'hA0, 8'h08, 1'b1, 1'b0, 1'b0));
    exp_rsp_q.push_back(mk_rsp(64'hA1, 8'h08, 1'b1, 1'b1, 1'b0));
    send_req(C_RD_SIZE, 64'h0102_0304_0506_0708, 16'd2);
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    req_valid = 1'b1; req_cmd = 8'h09;
    repeat (10) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    check("no_redrive_before_hs", 64'(exp_q.size()), 64'd2);
    check("bp_reg_in_bus_held", reg_in_bus, 64'h0102_0304_0506_0708);
    rsp_ready = 1'b1;
    wait_done(200);

    // Burst of zero behaves as one
    core_val = 64'h77;
    exp_q.push_back(C_RD_TRIG); exp_q.push_back(C_ACK);
    exp_rsp_q.push_back(mk_rsp(64'h77, 8'h08, 1'b1, 1'b1, 1'b0));
    send_req(C_RD_TRIG, 64'hFFFF_0000_FFFF_0000, 16'd0);
    wait_done(100);

    // Asynchronous reset while waiting for ack
    ack_en = 1'b0;
    exp_q.push_back(C_RD_DATA);
    send_req(C_RD_DATA, 64'h55, 16'd3);
    repeat (5) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_rsp_q.delete();
    ack_en  = 1'b1;
    ack_cnt = 0;
    @(posedge clk); #3 resetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midreset", {63'd0, req_ready}, 64'd1);
    core_val = 64'hCAFE;
    exp_q.push_back(C_RD_TRIG); exp_q.push_back(C_ACK);
    exp_rsp_q.push_back(mk_rsp(64'hCAFE, 8'h08, 1'b1, 1'b1, 1'b0));
    send_req(C_RD_TRIG, 64'h1234, 16'd1);
    wait_done(100);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
